// File: rtl/serial_frame_tx_if.sv
// Word handshake between the upstream message logic (master) and serial_frame_tx (slave).
interface serial_frame_tx_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_valid;
   logic                 tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/serial_frame_tx.sv
// Asynchronous serial frame transmitter: start, DATA_BITS LSB first, optional even parity, stop bit(s).
// Define SERIAL_FRAME_TX_PARITY_EN to insert the parity bit between the data and the stop bit(s).
//
// state    | meaning
// ---------+------------------------------------------------------
// S_IDLE   | line high, tx_ready high, waiting for a word
// S_ARMED  | word latched, line high until the next bit_tick
// S_START  | start bit (0) on the line
// S_DATA   | data bits on the line, LSB first
// S_PARITY | even parity bit on the line (parity build only)
// S_STOP   | stop bit(s) on the line
module serial_frame_tx #(
   parameter int DATA_BITS = 8,
   parameter int STOP_BITS = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             bit_tick_i,
   serial_frame_tx_if.slave tx_if,
   output logic             tx_out_o,
   output logic             tx_busy_o,
   output logic             frame_done_o
);
   localparam int               IDX_W     = $clog2(DATA_BITS);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
   localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

`ifdef SERIAL_FRAME_TX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_ARMED, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_ARMED, S_START, S_DATA, S_STOP} state_t;
`endif

   state_t               state_q;
   logic [DATA_BITS-1:0] shift_q;
   logic [IDX_W-1:0]     idx_q;
   logic                 stop_cnt_q;
   logic                 tx_out_q;
   logic                 tx_ready_q;
   logic                 tx_busy_q;
   logic                 frame_done_q;
`ifdef SERIAL_FRAME_TX_PARITY_EN
   logic                 parity_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         shift_q      <= '0;
         idx_q        <= '0;
         stop_cnt_q   <= 1'b0;
         tx_out_q     <= 1'b1;
         tx_ready_q   <= 1'b1;
         tx_busy_q    <= 1'b0;
         frame_done_q <= 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
         parity_q     <= 1'b0;
`endif
      end else begin
         frame_done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               // a tick arriving with the word is deliberately not used for alignment
               if (tx_if.tx_valid && tx_ready_q) begin
                  shift_q    <= tx_if.tx_data;
                  idx_q      <= '0;
                  tx_ready_q <= 1'b0;
                  tx_busy_q  <= 1'b1;
                  state_q    <= S_ARMED;
`ifdef SERIAL_FRAME_TX_PARITY_EN
                  parity_q   <= ^tx_if.tx_data;
`endif
               end
            end
            S_ARMED: begin
               if (bit_tick_i) begin
                  tx_out_q <= 1'b0;
                  state_q  <= S_START;
               end
            end
            S_START: begin
               if (bit_tick_i) begin
                  tx_out_q <= shift_q[0];
                  shift_q  <= shift_q >> 1;
                  idx_q    <= '0;
                  state_q  <= S_DATA;
               end
            end
            S_DATA: begin
               if (bit_tick_i) begin
                  if (idx_q != LAST_IDX) begin
                     tx_out_q <= shift_q[0];
                     shift_q  <= shift_q >> 1;
                     idx_q    <= idx_q + 1'b1;
                  end else begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
                     tx_out_q <= parity_q;
                     state_q  <= S_PARITY;
`else
                     tx_out_q   <= 1'b1;
                     stop_cnt_q <= 1'b0;
                     state_q    <= S_STOP;
`endif
                  end
               end
            end
`ifdef SERIAL_FRAME_TX_PARITY_EN
            S_PARITY: begin
               if (bit_tick_i) begin
                  tx_out_q   <= 1'b1;
                  stop_cnt_q <= 1'b0;
                  state_q    <= S_STOP;
               end
            end
`endif
            S_STOP: begin
               if (bit_tick_i) begin
                  if (stop_cnt_q != STOP_LAST) begin
                     stop_cnt_q <= stop_cnt_q + 1'b1;
                  end else begin
                     frame_done_q <= 1'b1;
                     tx_busy_q    <= 1'b0;
                     tx_ready_q   <= 1'b1;
                     state_q      <= S_IDLE;
                  end
               end
            end
            default: begin
               tx_out_q   <= 1'b1;
               tx_ready_q <= 1'b1;
               tx_busy_q  <= 1'b0;
               state_q    <= S_IDLE;
            end
         endcase
      end
   end

   assign tx_if.tx_ready = tx_ready_q;
   assign tx_out_o       = tx_out_q;
   assign tx_busy_o      = tx_busy_q;
   assign frame_done_o   = frame_done_q;
endmodule
